wb_sram_bridge: RTL
===================

# wb_sram_bridge

Wishbone classic responder that lets the Caravel management core read and write one sky130 OpenRAM 32x512 macro port (csb0/web0/wmask0/addr0/din0/dout0), e.g. to preload IRAM before the core is released from reset. It sits between the user-area Wishbone slave bus and the SRAM's port-0 pins. It is gated by an enable bit from the logic analyzer.

## Interface
Parameters:
- ADDR_WIDTH_WORDS, 9, SRAM word-address width (512 words, 2 KB window)
- BASE_ADDR, 32'h3000_0000, byte base of the window; only bits [31:ADDR_WIDTH_WORDS+2] are compared

Ports:
- clk_i  in  1  bus clock; also forwarded to the SRAM
- rstn_i  in  1  reset; **one clock; reset is synchronous and active-low**
- en_i  in  1  bridge enable (LA bit); 0 = new requests not accepted
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic control
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data, valid only while wbs_ack_o=1
- sram_clk0  out  1  = clk_i
- sram_csb0, sram_web0  out  1 each  active-low chip select / write enable
- sram_wmask0  out  4  byte write mask
- sram_addr0  out  ADDR_WIDTH_WORDS  word address = wbs_adr_i[ADDR_WIDTH_WORDS+1:2]
- sram_din0  out  32  = wbs_dat_i
- sram_dout0  in  32  SRAM read data, valid the cycle after the capture edge

## Operation
- req = cyc & stb & en_i & (state==IDLE); hit = upper address bits match BASE_ADDR.
- FSM states: IDLE, RD_WAIT, ACK.
  - IDLE, req & hit & we: csb0=0, web0=0, wmask0=sel_i, combinationally this cycle -> ACK.
  - IDLE, req & hit & !we: csb0=0, web0=1, wmask0=0 -> RD_WAIT.
  - IDLE, req & !hit: no SRAM access (csb0=1) -> ACK, read data 0, writes dropped.
  - RD_WAIT: register sram_dout0 into wbs_dat_o -> ACK.
  - ACK: wbs_ack_o=1 for exactly this cycle; SRAM idle -> IDLE unconditionally.
- Outside an IDLE accept, csb0=1, web0=1, wmask0=0.
- wbs_dat_o is zeroed on write and miss acks. It holds its value otherwise.
- en_i falling mid-transaction does not abort it; the in-flight access completes and acks.
- sel_i=0 on write: ack issued, no bytes modified. Sub-word reads return the full word.

## Timing
- Request first valid in cycle T. Write/miss: ack in T+1. Read: SRAM captures at end of T, data on dout0 in T+1, ack plus wbs_dat_o in T+2.
- Back-to-back: the master drops or renews stb after the ack edge. A new request is accepted in the cycle after ACK.
- Throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- Reset (rstn_i=0 at a rising edge): state=IDLE, wbs_ack_o=0, wbs_dat_o=0. While rstn_i=0, csb0=1, web0=1, wmask0=0 regardless of bus inputs.
- Reset mid-transaction: the pending ack is discarded and never issued after reset release.
- No combinational path from bus inputs to wbs_ack_o or wbs_dat_o.

## Structure
- FSM state encodings and the default BASE_ADDR go in the shared defines include, next to the existing IRAM/DRAM address-width constants.
- Single flat module; no sub-module is warranted.

## Test plan
- Reset with cyc=stb=1 held, then release: csb0=1 during reset, ack=0, dat_o=0. The first accepted request starts only after release.
- Write 0xDEADBEEF to 0x3000_0010 with sel=4'hF: csb0=0, web0=0, addr0=4, wmask0=F in T; ack in T+1. Read back the same address: ack in T+2, dat_o=0xDEADBEEF.
- Write 0x000000AA with sel=4'b0001 over 0x11223344: read returns 0x112233AA.
- Access to 0x3000_0800 (outside the 2 KB window): no csb0 pulse, ack in T+1. A read returns 0.
- en_i=0 with stb held for 10 cycles: no ack, csb0 stays 1. Raise en_i: normal completion. Drop en_i in RD_WAIT: ack still issued.
- rstn_i=0 asserted in RD_WAIT: no ack in the following cycles. The next read after release behaves normally.

Source files
------------

// File: rtl/wb_sram_bridge_pkg.sv
// Shared constants for the Wishbone-to-OpenRAM bridge: address widths, default
// window base and FSM state encoding.
package wb_sram_bridge_pkg;

  localparam int unsigned IRAM_ADDR_WIDTH = 9;
  localparam int unsigned DRAM_ADDR_WIDTH = 9;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned SEL_WIDTH       = 4;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ACK     = 2'd2
  } state_e;

endpackage

// File: rtl/wb_sram_bridge.sv
// Wishbone classic responder driving port 0 of a 32-bit OpenRAM macro.
// Writes and out-of-window accesses ack after one cycle, reads after two.
module wb_sram_bridge
  import wb_sram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH_WORDS = IRAM_ADDR_WIDTH,
  parameter logic [31:0] BASE_ADDR        = DEFAULT_BASE_ADDR
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        en_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_we_i,
  input  logic [SEL_WIDTH-1:0]        wbs_sel_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]       wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic [DATA_WIDTH-1:0]       wbs_dat_o,
  output logic                        sram_clk0,
  output logic                        sram_csb0,
  output logic                        sram_web0,
  output logic [SEL_WIDTH-1:0]        sram_wmask0,
  output logic [ADDR_WIDTH_WORDS-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0]       sram_din0,
  input  logic [DATA_WIDTH-1:0]       sram_dout0
);

  localparam int unsigned TAG_LSB = ADDR_WIDTH_WORDS + 2;

  state_e state;
  state_e state_nxt;
  logic   req;
  logic   hit;
  logic   dat_clr;
  logic   dat_load;
  logic   unused_adr_lsb;

  assign sram_clk0  = clk_i;
  assign sram_addr0 = wbs_adr_i[ADDR_WIDTH_WORDS+1:2];
  assign sram_din0  = wbs_dat_i;

  // Byte offset within the word is irrelevant: the SRAM is word addressed.
  assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

  assign hit = (wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign req = wbs_cyc_i & wbs_stb_i & en_i & (state == ST_IDLE);

  // Next state and SRAM strobes; the SRAM is only touched on an IDLE accept.
  always_comb begin
    state_nxt   = state;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    dat_clr     = 1'b0;
    dat_load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (hit && wbs_we_i) begin
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = wbs_sel_i;
            dat_clr     = 1'b1;
            state_nxt   = ST_ACK;
          end else if (hit) begin
            sram_csb0 = 1'b0;
            state_nxt = ST_RD_WAIT;
          end else begin
            dat_clr   = 1'b1;
            state_nxt = ST_ACK;
          end
        end
      end
      ST_RD_WAIT: begin
        dat_load  = 1'b1;
        state_nxt = ST_ACK;
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // Keep the macro quiet while held in reset, whatever the bus does.
    if (!rstn_i) begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= ST_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      state     <= state_nxt;
      wbs_ack_o <= (state_nxt == ST_ACK);
      if (dat_clr) begin
        wbs_dat_o <= '0;
      end else if (dat_load) begin
        wbs_dat_o <= sram_dout0;
      end
    end
  end

endmodule
